// File: rtl/usbf_ep_manager_if.sv
// Single-master classic Wishbone bus between the endpoint manager and the USB core.
// master drives address/data/strobe; slave returns read data and ack.
interface usbf_ep_manager_if #(
    parameter int ADDR_W = 18
);
    logic [ADDR_W-1:0] wb_addr_o;
    logic [31:0]       wb_data_o;
    logic [31:0]       wb_data_i;
    logic              wb_we_o;
    logic              wb_stb_o;
    logic              wb_cyc_o;
    logic              wb_ack_i;

    modport master (
        output wb_addr_o, wb_data_o, wb_we_o, wb_stb_o, wb_cyc_o,
        input  wb_data_i, wb_ack_i
    );

    modport slave (
        input  wb_addr_o, wb_data_o, wb_we_o, wb_stb_o, wb_cyc_o,
        output wb_data_i, wb_ack_i
    );
endinterface

// File: rtl/usbf_ep_manager.sv
// Endpoint manager: initialises the USB core registers over Wishbone, then services
// level interrupts by reading INT_SRC and the lowest pending endpoint's EP_INT.
// Handshake: cyc == stb, both registered; address/data/we stay stable until the
// ack cycle, and the strobe drops on the cycle after ack is sampled high.
module usbf_ep_manager #(
    parameter int              NUM_EP       = 2,
    parameter int              ADDR_W       = 18,
    parameter int              TIMEOUT      = 255,
    parameter logic [31:0]     INT_MSK_INIT = 32'h000000ff,
    parameter logic [NUM_EP*32-1:0] EP_CSR_INIT  = '0,
    parameter logic [NUM_EP*32-1:0] EP_INT_INIT  = '0,
    parameter logic [NUM_EP*32-1:0] EP_BUF0_INIT = '0,
    parameter logic [NUM_EP*32-1:0] EP_BUF1_INIT = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    usbf_ep_manager_if.master wb,
    input  logic              inta_i,
    input  logic              intb_i,
    output logic              init_done_o,
    output logic              ep_event_o,
    output logic [1:0]        ep_idx_o,
    output logic [31:0]       ep_status_o,
    output logic              usb_rst_o,
    output logic              wb_err_o,
    output logic [3:0]        state_o
);
    typedef enum logic [3:0] {
        INIT_FA  = 4'd1,
        INIT_MSK = 4'd2,
        INIT_EP  = 4'd3,
        IDLE     = 4'd4,
        RD_SRC   = 4'd5,
        DISPATCH = 4'd6,
        RD_EP    = 4'd7,
        REPORT   = 4'd8,
        WAIT_ACK = 4'd9
    } state_t;

    state_t              state_q, ret_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         data_q;
    logic                we_q, stb_q;
    logic [15:0]         to_cnt_q;
    logic [1:0]          ep_cnt_q, reg_cnt_q, ep_sel_q;
    logic                src_rst_q;
    logic [NUM_EP-1:0]   src_ep_q;

    logic                ep_hit;
    logic [1:0]          ep_next;
    logic [7:0]          init_off;
    logic [31:0]         init_data;

    assign wb.wb_addr_o = addr_q;
    assign wb.wb_data_o = data_q;
    assign wb.wb_we_o   = we_q;
    assign wb.wb_stb_o  = stb_q;
    assign wb.wb_cyc_o  = stb_q;
    assign state_o      = state_q;

    // Lowest pending endpoint wins; loop runs high-to-low so the last hit is the lowest.
    always_comb begin
        ep_hit  = 1'b0;
        ep_next = 2'd0;
        for (int i = NUM_EP - 1; i >= 0; i--) begin
            if (src_ep_q[i]) begin
                ep_hit  = 1'b1;
                ep_next = 2'(i);
            end
        end
    end

    always_comb begin
        init_off = 8'h40 + {2'b00, ep_cnt_q, reg_cnt_q, 2'b00};
        case (reg_cnt_q)
            2'd0:    init_data = EP_CSR_INIT[32*int'(ep_cnt_q) +: 32];
            2'd1:    init_data = EP_INT_INIT[32*int'(ep_cnt_q) +: 32];
            2'd2:    init_data = EP_BUF0_INIT[32*int'(ep_cnt_q) +: 32];
            default: init_data = EP_BUF1_INIT[32*int'(ep_cnt_q) +: 32];
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= INIT_FA;
            ret_q       <= INIT_FA;
            addr_q      <= '0;
            data_q      <= '0;
            we_q        <= 1'b0;
            stb_q       <= 1'b0;
            to_cnt_q    <= '0;
            ep_cnt_q    <= '0;
            reg_cnt_q   <= '0;
            ep_sel_q    <= '0;
            src_rst_q   <= 1'b0;
            src_ep_q    <= '0;
            init_done_o <= 1'b0;
            ep_event_o  <= 1'b0;
            ep_idx_o    <= '0;
            ep_status_o <= '0;
            usb_rst_o   <= 1'b0;
            wb_err_o    <= 1'b0;
        end else begin
            ep_event_o <= 1'b0;
            usb_rst_o  <= 1'b0;
            case (state_q)
                INIT_FA: begin
                    addr_q   <= ADDR_W'(8'h04);
                    data_q   <= 32'h0;
                    we_q     <= 1'b1;
                    stb_q    <= 1'b1;
                    to_cnt_q <= '0;
                    ret_q    <= INIT_FA;
                    state_q  <= WAIT_ACK;
                end
                INIT_MSK: begin
                    addr_q   <= ADDR_W'(8'h08);
                    data_q   <= INT_MSK_INIT;
                    we_q     <= 1'b1;
                    stb_q    <= 1'b1;
                    to_cnt_q <= '0;
                    ret_q    <= INIT_MSK;
                    state_q  <= WAIT_ACK;
                end
                INIT_EP: begin
                    addr_q   <= ADDR_W'(init_off);
                    data_q   <= init_data;
                    we_q     <= 1'b1;
                    stb_q    <= 1'b1;
                    to_cnt_q <= '0;
                    ret_q    <= INIT_EP;
                    state_q  <= WAIT_ACK;
                end
                IDLE: begin
                    if (inta_i || intb_i) state_q <= RD_SRC;
                end
                RD_SRC: begin
                    addr_q   <= ADDR_W'(8'h0C);
                    we_q     <= 1'b0;
                    stb_q    <= 1'b1;
                    to_cnt_q <= '0;
                    ret_q    <= RD_SRC;
                    state_q  <= WAIT_ACK;
                end
                DISPATCH: begin
                    if (src_rst_q) begin
                        usb_rst_o   <= 1'b1;
                        init_done_o <= 1'b0;
                        state_q     <= INIT_FA;
                    end else if (ep_hit) begin
                        ep_sel_q <= ep_next;
                        state_q  <= RD_EP;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RD_EP: begin
                    addr_q   <= ADDR_W'(8'h44 + {2'b00, ep_sel_q, 4'h0});
                    we_q     <= 1'b0;
                    stb_q    <= 1'b1;
                    to_cnt_q <= '0;
                    ret_q    <= RD_EP;
                    state_q  <= WAIT_ACK;
                end
                REPORT: begin
                    state_q <= IDLE;
                end
                WAIT_ACK: begin
                    if (wb.wb_ack_i && stb_q) begin
                        stb_q <= 1'b0;
                        we_q  <= 1'b0;
                        case (ret_q)
                            INIT_FA:  state_q <= INIT_MSK;
                            INIT_MSK: begin
                                ep_cnt_q  <= '0;
                                reg_cnt_q <= '0;
                                state_q   <= INIT_EP;
                            end
                            INIT_EP: begin
                                reg_cnt_q <= reg_cnt_q + 2'd1;
                                if (reg_cnt_q == 2'd3) begin
                                    if (ep_cnt_q == 2'(NUM_EP - 1)) begin
                                        init_done_o <= 1'b1;
                                        state_q     <= IDLE;
                                    end else begin
                                        ep_cnt_q <= ep_cnt_q + 2'd1;
                                        state_q  <= INIT_EP;
                                    end
                                end else begin
                                    state_q <= INIT_EP;
                                end
                            end
                            RD_SRC: begin
                                src_rst_q <= wb.wb_data_i[28] | wb.wb_data_i[25];
                                src_ep_q  <= wb.wb_data_i[NUM_EP-1:0];
                                state_q   <= DISPATCH;
                            end
                            RD_EP: begin
                                ep_status_o <= wb.wb_data_i;
                                ep_idx_o    <= ep_sel_q;
                                ep_event_o  <= 1'b1;
                                state_q     <= REPORT;
                            end
                            default: state_q <= IDLE;
                        endcase
                    end else if (to_cnt_q == 16'(TIMEOUT - 1)) begin
                        // Abandon the access; init_done stays as it was, so an aborted init stays low.
                        stb_q    <= 1'b0;
                        we_q     <= 1'b0;
                        wb_err_o <= 1'b1;
                        state_q  <= IDLE;
                    end else begin
                        to_cnt_q <= to_cnt_q + 16'd1;
                    end
                end
                default: state_q <= INIT_FA;
            endcase
        end
    end
endmodule

// File: doc/usbf_ep_manager.md
USBF_EP_MANAGER -- requirements
Module: usbf_ep_manager

Interface
REQ-001 SHALL have parameter NUM_EP, default 2: endpoints configured and serviced; legal range 1..4.
REQ-002 SHALL have parameter ADDR_W, default 18: Wishbone address width; bit ADDR_W-1 = 0 selects the register file.
REQ-003 SHALL have parameter TIMEOUT, default 255: maximum cycles waited for wb_ack_i; legal range 1..65535.
REQ-004 SHALL have parameter INT_MSK_INIT, default 32'h000000ff: value written to INT_MSK.
REQ-005 SHALL have parameters EP_CSR_INIT, EP_INT_INIT, EP_BUF0_INIT and EP_BUF1_INIT, each NUM_EP*32 bits: per-endpoint init values; slice i = bits [32i+31:32i].
REQ-006 SHALL have port clk_i, input, 1 bit: the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-008 SHALL have ports wb_addr_o (out, ADDR_W), wb_data_o (out, 32), wb_data_i (in, 32), wb_we_o, wb_stb_o, wb_cyc_o (out, 1 each) and wb_ack_i (in, 1): the Wishbone master.
REQ-009 SHALL have ports inta_i and intb_i, input, 1 bit each: core interrupts, level-sensitive.
REQ-010 SHALL have status output ports:
- init_done_o (1): high while the init sequence is complete.
- ep_event_o (1): one-cycle pulse when an endpoint is serviced.
- ep_idx_o (2): serviced endpoint index.
- ep_status_o (32): latched EP_INT value.
- usb_rst_o (1): one-cycle pulse on USB reset/attach.
- wb_err_o (1): sticky bus-timeout flag.
- state_o (4): state encoding for debug/LEDs.

Function
REQ-011 SHALL issue only single classic Wishbone cycles:
- wb_cyc_o = wb_stb_o, asserted from registers.
- wb_addr_o, wb_data_o and wb_we_o held stable until the ack cycle.
- wb_cyc_o, wb_stb_o and wb_we_o deasserted on the cycle after wb_ack_i is sampled high.
REQ-012 SHALL assert wb_stb_o in the cycle after entering a state that issues an access, and SHALL leave at least one idle cycle (wb_cyc_o = 0) between consecutive accesses.
REQ-013 SHALL form each address as {1'b0, byte offset zero-extended to ADDR_W-1 bits}.
REQ-014 SHALL run this init sequence, in this order, after reset and on every re-init:
- write 0 to FA (0x04).
- write INT_MSK_INIT to INT_MSK (0x08).
- for each i = 0..NUM_EP-1: write CSR (0x40+0x10i), INT (0x44+0x10i), BUF0 (0x48+0x10i), BUF1 (0x4C+0x10i) with the slice-i init values.
REQ-015 SHALL hold init_done_o low from the cycle re-init starts and SHALL drive it high in the cycle after the final init write is acked.
REQ-016 SHALL use states and state_o codes INIT_FA=1, INIT_MSK=2, INIT_EP=3, IDLE=4, RD_SRC=5, DISPATCH=6, RD_EP=7, REPORT=8, WAIT_ACK=9.
- INIT_EP SHALL sequence using an endpoint counter (0..NUM_EP-1) and a register counter (0..3).
REQ-017 In IDLE with inta_i|intb_i high, SHALL read INT_SRC (0x0C), latch wb_data_i on ack, then enter DISPATCH.
REQ-018 In DISPATCH, SHALL apply this priority:
- if src[28]|src[25]: pulse usb_rst_o and restart at INIT_FA.
- else if any src[i] is set for i < NUM_EP: select the lowest such i and read EP_INT(i).
- else: return to IDLE.
- src bits at or above NUM_EP in [3:0] SHALL be ignored.
REQ-019 On ack of the EP_INT read, SHALL enter REPORT; in REPORT, SHALL load ep_status_o = data and ep_idx_o = i, pulse ep_event_o for exactly one cycle, then go to IDLE.
REQ-020 SHALL re-evaluate level interrupts only from IDLE, so that there is at least one IDLE cycle between services.
REQ-021 SHALL count cycles in WAIT_ACK from first stb; if TIMEOUT cycles elapse with no ack, SHALL drop cyc/stb, set wb_err_o, and go to IDLE.
- A timeout during init SHALL leave init_done_o low; a later USB reset/attach retries init.
REQ-022 SHALL treat wb_ack_i sampled while wb_cyc_o = 0 as ignored.
REQ-023 SHALL ignore interrupts while in the init states.

Reset
REQ-024 While rst_i is high at a clock edge:
- SHALL drive all wb outputs, init_done_o, ep_event_o, usb_rst_o and wb_err_o to 0.
- SHALL clear ep_idx_o and ep_status_o.
- SHALL set state to INIT_FA.
REQ-025 On reset asserted mid-transfer, SHALL drop wb_cyc_o in the next cycle and restart init from FA after rst_i falls.

Verification
REQ-026 NUM_EP=2, slave acks 1 cycle after stb -> 10 writes in order 0x04,0x08,0x40,0x44,0x48,0x4C,0x50,0x54,0x58,0x5C with the parameter data; then init_done_o=1 and state_o=4.
REQ-027 inta_i high, INT_SRC returns 0x00000003, EP_INT(0) returns 0x00000011 -> read 0x44; ep_idx_o=0, ep_status_o=0x11, one-cycle ep_event_o; after ≥1 IDLE cycle, re-read of 0x0C.
REQ-028 INT_SRC returns 0x10000002 -> usb_rst_o pulse, init_done_o falls, full 10-write init repeats, no EP_INT read.
REQ-029 Slave never acks the 0x08 write with TIMEOUT=8 -> stb high exactly 8 cycles, then wb_err_o=1, state_o=4, init_done_o=0.
REQ-030 NUM_EP=1, INT_SRC=0x00000002 -> no EP read, return to IDLE; rst_i pulsed during the EP0 BUF1 write -> cyc drops the next cycle and init restarts at 0x04.
